// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, branch flushes, data-memory wait with timeout.
// Optional stall-cycle performance counter is built only when STALL_PERF_EN is defined.
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_use_stall,
  input  logic              branch_taken,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_write,
  output logic              mem_wb_bubble,
  output logic              mem_timeout_err,
  output logic [PERF_W-1:0] stall_cycles
);

  // state    | meaning
  // INIT     | first cycle after reset, flush every stage
  // RUN      | normal issue, hazard rules applied
  // MEM_WAIT | pipeline frozen on an outstanding data-memory access
  // ERR      | memory timed out, frozen until reset
  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERR      = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_INIT: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d    = ST_INIT;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        ex_mem_write  = 1'b0;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        mem_wb_bubble = 1'b1;
      end
      ST_RUN, ST_MEM_WAIT: begin
        // MEM_WAIT freezes on !ready alone; a new request is only needed to enter the wait
        if (!dmem_ready && (dmem_req || state_q == ST_MEM_WAIT)) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          ex_mem_write  = 1'b0;
          mem_wb_bubble = 1'b1;
        end else if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use_stall) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      default: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_bubble = 1'b1;
      end
    endcase
  end

  assign mem_timeout_err = (state_q == ST_ERR);

`ifdef STALL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q != ST_INIT && !pc_write && stall_cnt_q != {PERF_W{1'b1}})
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed vector table, hand sequences and random stimulus
// checked against a cycle-level reference model; two instances (timeout 15 and 3).
module tb_pipeline_stall_ctrl;

  localparam int PERF_W = 16;
  localparam logic [5:0] O_RST = 6'b001101;
  localparam logic [5:0] O_DEF = 6'b110010;
  localparam logic [5:0] O_FRZ = 6'b000001;
  localparam logic [5:0] O_BR  = 6'b111110;
  localparam logic [5:0] O_LU  = 6'b000110;

  logic clk = 1'b0;
  logic rst, lu, br, req, rdy;
  always #5 clk = ~clk;

  logic pc_a, ifw_a, iff_a, idf_a, exw_a, bub_a, err_a;
  logic pc_b, ifw_b, iff_b, idf_b, exw_b, bub_b, err_b;
  logic [PERF_W-1:0] perf_a, perf_b;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(15), .PERF_W(PERF_W)) dut_a (
    .clk(clk), .rst(rst), .load_use_stall(lu), .branch_taken(br),
    .dmem_req(req), .dmem_ready(rdy), .pc_write(pc_a), .if_id_write(ifw_a),
    .if_id_flush(iff_a), .id_ex_flush(idf_a), .ex_mem_write(exw_a),
    .mem_wb_bubble(bub_a), .mem_timeout_err(err_a), .stall_cycles(perf_a));

  pipeline_stall_ctrl #(.MEM_TIMEOUT(3), .PERF_W(PERF_W)) dut_b (
    .clk(clk), .rst(rst), .load_use_stall(lu), .branch_taken(br),
    .dmem_req(req), .dmem_ready(rdy), .pc_write(pc_b), .if_id_write(ifw_b),
    .if_id_flush(iff_b), .id_ex_flush(idf_b), .ex_mem_write(exw_b),
    .mem_wb_bubble(bub_b), .mem_timeout_err(err_b), .stall_cycles(perf_b));

  wire [5:0] outs_a = {pc_a, ifw_a, iff_a, idf_a, exw_a, bub_a};
  wire [5:0] outs_b = {pc_b, ifw_b, iff_b, idf_b, exw_b, bub_b};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: counts consecutive frozen cycles instead of tracking FSM states
  int          tmo_m[2] = '{15, 3};
  bit          init_m[2];
  int          frozen_m[2];
  bit          err_m[2];
  int unsigned perf_m[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [5:0] model_outs(input int k);
    if (rst || init_m[k])                      return O_RST;
    if (err_m[k])                              return O_FRZ;
    if (!rdy && (frozen_m[k] > 0 || req))      return O_FRZ;
    if (br)                                    return O_BR;
    if (lu)                                    return O_LU;
    return O_DEF;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      init_m[k] = 1'b1; frozen_m[k] = 0; err_m[k] = 1'b0; perf_m[k] = 0;
    end
  endtask

  task automatic model_edge(input int k, input logic [5:0] o);
    if (rst) begin
      init_m[k] = 1'b1; frozen_m[k] = 0; err_m[k] = 1'b0; perf_m[k] = 0;
      return;
    end
    if (!init_m[k] && !o[5] && perf_m[k] < (2**PERF_W) - 1) perf_m[k]++;
    if (init_m[k]) init_m[k] = 1'b0;
    else if (!err_m[k]) begin
      if (o == O_FRZ) begin
        frozen_m[k]++;
        // the entering RUN cycle plus MEM_TIMEOUT wait cycles, then error
        if (frozen_m[k] > tmo_m[k]) err_m[k] = 1'b1;
      end else frozen_m[k] = 0;
    end
  endtask

  function automatic logic [31:0] exp_perf(input int k);
`ifdef STALL_PERF_EN
    return perf_m[k];
`else
    return 0;
`endif
  endfunction

  // Called just after a posedge: drive, compare mid-cycle, clock, update the model.
  task automatic step(input logic r, input logic l, input logic b, input logic q, input logic y);
    logic [5:0] oa, ob;
    rst = r; lu = l; br = b; req = q; rdy = y;
    if (r) model_reset();
    #4;
    oa = model_outs(0);
    ob = model_outs(1);
    chk("outs_a", 32'(outs_a), 32'(oa));
    chk("outs_b", 32'(outs_b), 32'(ob));
    chk("err_a", 32'(err_a), 32'(err_m[0]));
    chk("err_b", 32'(err_b), 32'(err_m[1]));
    chk("perf_a", 32'(perf_a), exp_perf(0));
    chk("perf_b", 32'(perf_b), exp_perf(1));
    @(posedge clk);
    model_edge(0, oa);
    model_edge(1, ob);
    #1;
  endtask

  typedef struct {
    logic       r, l, b, q, y;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[16];

  initial begin
    vt[0]  = '{1,0,0,0,0, O_RST};
    vt[1]  = '{1,1,1,1,0, O_RST};
    vt[2]  = '{1,0,0,0,0, O_RST};
    vt[3]  = '{0,1,0,0,0, O_RST};   // INIT ignores requests
    vt[4]  = '{0,0,0,0,0, O_DEF};
    vt[5]  = '{0,1,0,0,0, O_LU};
    vt[6]  = '{0,0,0,0,0, O_DEF};
    vt[7]  = '{0,1,1,0,0, O_BR};
    vt[8]  = '{0,0,0,1,0, O_FRZ};
    vt[9]  = '{0,0,0,1,0, O_FRZ};
    vt[10] = '{0,1,0,1,0, O_FRZ};
    vt[11] = '{0,0,1,1,0, O_FRZ};
    vt[12] = '{0,0,0,1,1, O_DEF};
    vt[13] = '{0,0,0,1,1, O_DEF};
    vt[14] = '{0,0,0,0,0, O_DEF};
    vt[15] = '{0,1,1,1,0, O_FRZ};

    rst = 1'b1; lu = 0; br = 0; req = 0; rdy = 0;
    model_reset();

    for (int i = 0; i < 15; i++) begin
      rst = vt[i].r; lu = vt[i].l; br = vt[i].b; req = vt[i].q; rdy = vt[i].y;
      #1;
      chk($sformatf("vec%0d", i), 32'(outs_a), 32'(vt[i].exp));
      #0;
      rst = 1'b0;
      step(vt[i].r, vt[i].l, vt[i].b, vt[i].q, vt[i].y);
    end
    chk("err_a_after_4wait", 32'(err_a), 32'd0);
`ifdef STALL_PERF_EN
    chk("perf_after_lu_wait", 32'(perf_a), 32'd5);
`endif

    // Timeout on the MEM_TIMEOUT=3 instance, then late ready and async clear
    step(1,0,0,0,0);
    step(0,0,0,0,0);
    for (int i = 0; i < 6; i++) step(0,0,0,1,0);
    chk("err_b_timeout", 32'(err_b), 32'd1);
    chk("err_a_no_timeout", 32'(err_a), 32'd0);
    for (int i = 0; i < 3; i++) step(0,0,0,1,1);
    chk("err_b_sticky", 32'(err_b), 32'd1);
    chk("outs_b_err_frozen", 32'(outs_b), 32'(O_FRZ));
    rst = 1'b1;
    #1;
    chk("err_b_async_clear", 32'(err_b), 32'd0);
    chk("outs_b_async_rst", 32'(outs_b), 32'(O_RST));
    step(1,0,0,0,0);

    // Release with a pending branch held across the wait
    step(0,0,0,0,0);
    step(0,0,1,1,0);
    step(0,0,1,1,0);
    rdy = 1'b1;
    #1;
    chk("release_branch_a", 32'(outs_a), 32'(O_BR));
    chk("release_branch_b", 32'(outs_b), 32'(O_BR));
    step(0,0,1,1,1);
    step(0,0,0,0,0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) == 0),
           1'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumer end of the hazard-detection interface. Takes the load-use stall request from the data-hazard unit, the taken-branch redirect from EX, and the data-memory handshake from MEM.
- Drives write-enables and flushes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Owns multi-cycle data-memory wait, timeout detection and the post-reset pipeline flush.

Parameters:
- MEM_TIMEOUT, 15: maximum MEM_WAIT cycles before the error state; legal range 1..255.
- PERF_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- load_use_stall  in  1  load-use hazard request from the data-hazard unit
- branch_taken  in  1  taken branch/jump resolved in EX
- dmem_req  in  1  MEM-stage instruction is accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID load NOP
- id_ex_flush  out  1  ID/EX load bubble (all control bits 0)
- ex_mem_write  out  1  ID/EX and EX/MEM enable (hold when 0)
- mem_wb_bubble  out  1  MEM/WB loads bubble (reg_write_enable 0)
- mem_timeout_err  out  1  sticky memory timeout flag
- stall_cycles  out  PERF_W  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high.
  - While rst=1: state=INIT, wait_cnt=0, mem_timeout_err=0, stall_cycles=0.
  - Outputs while rst=1: pc_write=0, if_id_write=0, ex_mem_write=0, if_id_flush=1, id_ex_flush=1, mem_wb_bubble=1.
- All outputs except the counters are combinational from the registered state and the current inputs, so there is zero-cycle latency from request to control.
- State INIT:
  - Lasts exactly one cycle after rst falls.
  - Outputs are the same as during reset, which flushes all stages.
  - Next state: RUN.
- State RUN default outputs: pc_write=1, if_id_write=1, ex_mem_write=1, all flushes and bubble 0.
- RUN priority rules, highest first:
  1. dmem_req=1 and dmem_ready=0: freeze the whole pipeline. pc_write=0, if_id_write=0, ex_mem_write=0, mem_wb_bubble=1. Next state MEM_WAIT, wait_cnt=1.
  2. branch_taken=1: pc_write=1, if_id_flush=1, id_ex_flush=1. A simultaneous load_use_stall is ignored because that instruction is on the wrong path.
  3. load_use_stall=1: pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1.
- State MEM_WAIT, dmem_ready=0:
  - Outputs are the same as the RUN freeze.
  - Each cycle, wait_cnt increments.
  - When wait_cnt==MEM_TIMEOUT and ready is still 0, next state is ERR.
- State MEM_WAIT, dmem_ready=1:
  - Outputs are evaluated with RUN rules 2–3, and rule 1 is skipped.
  - Next state RUN, wait_cnt=0.
  - branch_taken and load_use_stall are held stable by the frozen pipeline, so they are honoured on this release cycle.
- State ERR:
  - Terminal until rst.
  - Full freeze outputs.
  - mem_timeout_err=1 from the first ERR cycle on.
- wait_cnt is 8 bits and never wraps, because it leaves MEM_WAIT at MEM_TIMEOUT.
- rst asserted mid-MEM_WAIT or in ERR returns immediately to the reset outputs. The pending access is abandoned.

Optional Feature:
- Macro: STALL_PERF_EN.
- Defined:
  - stall_cycles increments on every clk edge where rst=0, state≠INIT and pc_write=0.
  - Saturates at 2^PERF_W−1.
  - Cleared only by rst.
- Undefined: stall_cycles is tied to 0 and no counter flops exist. The port list is unchanged.

Test Plan:
- Reset release: hold rst=1 for 3 cycles, then drop it.
  - During reset and the first cycle after: pc_write=0, if_id_flush=1, id_ex_flush=1, mem_wb_bubble=1.
  - Second cycle: pc_write=1, all flushes 0.
- Load-use: in RUN, pulse load_use_stall=1 for 1 cycle.
  - That cycle: pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1.
  - Next cycle: defaults. With STALL_PERF_EN, stall_cycles=1.
- Branch versus load-use: branch_taken=1 and load_use_stall=1 in the same cycle.
  - pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_write=1.
- Memory wait: dmem_req=1 with dmem_ready=0 for 4 cycles, then 1.
  - 4 freeze cycles (ex_mem_write=0, mem_wb_bubble=1), then release with defaults.
  - mem_timeout_err stays 0. With STALL_PERF_EN, stall_cycles=4.
- Timeout: MEM_TIMEOUT=3, dmem_req=1, dmem_ready=0 held.
  - ERR is entered after 3 wait cycles and mem_timeout_err=1.
  - Later dmem_ready=1 has no effect.
  - Asserting rst clears the flag asynchronously.
- Release with pending branch: MEM_WAIT with branch_taken=1 held, then dmem_ready=1.
  - Release cycle: pc_write=1, if_id_flush=1, id_ex_flush=1.
